// File: rtl/mc8051_psw.sv
// mc8051_psw: Program Status Word register.
// Merges ALU flag, bit-operation and direct SFR writes into one update per
// cycle, commits it immediately or parks it in a one-entry slot while the
// pipeline is held, and tracks accumulator parity every cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | slot empty; strobes accepted, o_ready = 1
// PEND  | slot full; waiting for i_hold to drop, strobes ignored
module mc8051_psw (
    input  logic       i_mcu_clk,
    input  logic       i_mcu_rst,
    input  logic       i_hold,
    input  logic       i_flag_we,
    input  logic [3:0] i_flag_mask,
    input  logic       i_cy,
    input  logic       i_ac,
    input  logic       i_ov,
    input  logic       i_zo,
    input  logic       i_bit_we,
    input  logic [2:0] i_bit_sel,
    input  logic       i_bit_val,
    input  logic       i_sfr_we,
    input  logic [7:0] i_sfr_wdata,
    input  logic [7:0] i_acc,
    output logic       o_ready,
    output logic [7:0] o_psw,
    output logic       o_cy_q,
    output logic       o_ac_q,
    output logic       o_ov_q,
    output logic       o_zo_q,
    output logic [1:0] o_rs
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam int BIT_CY = 7;
    localparam int BIT_AC = 6;
    localparam int BIT_OV = 2;

    logic [0:0] state_q;
    logic [0:0] state_nxt;
    logic       ready_q;

    // Writable PSW bits live in [7:1]; bit 0 of these vectors is unused
    // padding so PSW bit indices can be used directly.
    logic [7:0] psw_q;
    logic       par_q;
    logic       zo_q;

    logic [7:0] slot_psw_q;
    logic       slot_zo_q;

    logic       strobe;
    logic [7:0] merged_psw;
    logic       merged_zo;
    logic       commit_now;
    logic       commit_slot;
    logic       fill_slot;

    assign strobe = i_flag_we | i_bit_we | i_sfr_we;

    // Build the merged update: flags, then bit write, then SFR write.
    always_comb begin
        merged_psw = psw_q;
        merged_zo  = zo_q;
        if (i_flag_we) begin
            if (i_flag_mask[3]) merged_psw[BIT_CY] = i_cy;
            if (i_flag_mask[2]) merged_psw[BIT_AC] = i_ac;
            if (i_flag_mask[1]) merged_psw[BIT_OV] = i_ov;
            if (i_flag_mask[0]) merged_zo = i_zo;
        end
        if (i_bit_we && (i_bit_sel != 3'd0)) begin
            merged_psw[i_bit_sel] = i_bit_val;
        end
        if (i_sfr_we) begin
            merged_psw[7:1] = i_sfr_wdata[7:1];
        end
        // P is owned by the parity tracker, never by a write path.
        merged_psw[0] = 1'b0;
    end

    // Decide what happens at the next edge; strobes in PEND are dropped.
    always_comb begin
        state_nxt   = state_q;
        commit_now  = 1'b0;
        commit_slot = 1'b0;
        fill_slot   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    if (i_hold) begin
                        fill_slot = 1'b1;
                        state_nxt = ST_PEND;
                    end else begin
                        commit_now = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (!i_hold) begin
                    commit_slot = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sequencing state and the registered ready flag.
    always_ff @(posedge i_mcu_clk) begin
        if (i_mcu_rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt == ST_IDLE);
        end
    end

    // Pending slot holds one fully merged update while the pipeline stalls.
    always_ff @(posedge i_mcu_clk) begin
        if (i_mcu_rst) begin
            slot_psw_q <= 8'h00;
            slot_zo_q  <= 1'b0;
        end else if (fill_slot) begin
            slot_psw_q <= merged_psw;
            slot_zo_q  <= merged_zo;
        end
    end

    // Committed PSW bits [7:1] and the zero flag.
    always_ff @(posedge i_mcu_clk) begin
        if (i_mcu_rst) begin
            psw_q <= 8'h00;
            zo_q  <= 1'b0;
        end else if (commit_slot) begin
            psw_q <= slot_psw_q;
            zo_q  <= slot_zo_q;
        end else if (commit_now) begin
            psw_q <= merged_psw;
            zo_q  <= merged_zo;
        end
    end

    // Parity follows the accumulator every cycle, independent of stalls.
    always_ff @(posedge i_mcu_clk) begin
        if (i_mcu_rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^i_acc;
        end
    end

    assign o_psw   = {psw_q[7:1], par_q};
    assign o_cy_q  = psw_q[BIT_CY];
    assign o_ac_q  = psw_q[BIT_AC];
    assign o_ov_q  = psw_q[BIT_OV];
    assign o_zo_q  = zo_q;
    assign o_rs    = psw_q[4:3];
    assign o_ready = ready_q;

endmodule

// File: tb/tb_mc8051_psw.sv
// Directed bench for mc8051_psw: inputs change 1 time unit after a rising
// edge, outputs are checked 1 time unit after the following rising edge.
module tb_mc8051_psw;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       flag_we;
    logic [3:0] flag_mask;
    logic       cy, ac, ov, zo;
    logic       bit_we;
    logic [2:0] bit_sel;
    logic       bit_val;
    logic       sfr_we;
    logic [7:0] sfr_wdata;
    logic [7:0] acc;
    logic       ready;
    logic [7:0] psw;
    logic       cy_q, ac_q, ov_q, zo_q;
    logic [1:0] rs;

    int total = 0;
    int bad   = 0;

    mc8051_psw dut (
        .i_mcu_clk  (clk),
        .i_mcu_rst  (rst),
        .i_hold     (hold),
        .i_flag_we  (flag_we),
        .i_flag_mask(flag_mask),
        .i_cy       (cy),
        .i_ac       (ac),
        .i_ov       (ov),
        .i_zo       (zo),
        .i_bit_we   (bit_we),
        .i_bit_sel  (bit_sel),
        .i_bit_val  (bit_val),
        .i_sfr_we   (sfr_we),
        .i_sfr_wdata(sfr_wdata),
        .i_acc      (acc),
        .o_ready    (ready),
        .o_psw      (psw),
        .o_cy_q     (cy_q),
        .o_ac_q     (ac_q),
        .o_ov_q     (ov_q),
        .o_zo_q     (zo_q),
        .o_rs       (rs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        flag_we = 1'b0; flag_mask = 4'h0; cy = 1'b0; ac = 1'b0; ov = 1'b0; zo = 1'b0;
        bit_we = 1'b0; bit_sel = 3'd0; bit_val = 1'b0;
        sfr_we = 1'b0; sfr_wdata = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clear_strobes();
        hold = 1'b0;
        rst  = 1'b1;
        acc  = 8'h07;
        step();
        chk("rst_psw",   psw, 8'h00);
        chk("rst_zo",    {7'd0, zo_q}, 8'h00);
        chk("rst_ready", {7'd0, ready}, 8'h01);
        rst = 1'b0;
        step();
        chk("parity_07", psw, 8'h01);

        // Flag write: CY and ZO enabled only.
        acc = 8'h00;
        flag_we = 1'b1; flag_mask = 4'b1001; cy = 1; ac = 1; ov = 1; zo = 1;
        step();
        clear_strobes();
        chk("flag_psw", psw, 8'h80);
        chk("flag_ov",  {7'd0, ov_q}, 8'h00);
        chk("flag_zo",  {7'd0, zo_q}, 8'h01);

        // Flag write: AC and OV enabled, ZO masked off so it keeps 1.
        flag_we = 1'b1; flag_mask = 4'b0110; cy = 0; ac = 1; ov = 1; zo = 0;
        step();
        clear_strobes();
        chk("flag2_psw", psw, 8'hC4);
        chk("flag2_zo",  {7'd0, zo_q}, 8'h01);
        chk("flag2_ac",  {7'd0, ac_q}, 8'h01);

        // All three sources in one cycle; SFR write wins.
        flag_we = 1'b1; flag_mask = 4'b1000; cy = 0;
        bit_we = 1'b1; bit_sel = 3'd7; bit_val = 1'b1;
        sfr_we = 1'b1; sfr_wdata = 8'h18;
        step();
        clear_strobes();
        chk("merge_psw", psw, 8'h18);
        chk("merge_rs",  {6'd0, rs}, 8'h03);
        chk("merge_cy",  {7'd0, cy_q}, 8'h00);
        chk("merge_zo",  {7'd0, zo_q}, 8'h01);

        // Bit writes to F0 and RS0.
        bit_we = 1'b1; bit_sel = 3'd5; bit_val = 1'b1;
        step();
        chk("bit_f0", psw, 8'h38);
        bit_sel = 3'd3; bit_val = 1'b0;
        step();
        clear_strobes();
        chk("bit_rs0", psw, 8'h30);
        chk("bit_rs",  {6'd0, rs}, 8'h02);

        // Stalled SFR write: held for 3 cycles, parity still tracks acc.
        hold = 1'b1;
        sfr_we = 1'b1; sfr_wdata = 8'hFF;
        step();
        clear_strobes();
        chk("hold1_ready", {7'd0, ready}, 8'h00);
        chk("hold1_psw",   psw, 8'h30);
        step();
        chk("hold2_psw", psw, 8'h30);
        acc = 8'h01;
        step();
        chk("hold3_psw_par", psw, 8'h31);
        chk("hold3_ready",   {7'd0, ready}, 8'h00);
        acc  = 8'h00;
        hold = 1'b0;
        step();
        chk("release_psw",   psw, 8'hFE);
        chk("release_ready", {7'd0, ready}, 8'h01);

        // Strobe while PEND is ignored; slot content is preserved.
        hold = 1'b1;
        sfr_we = 1'b1; sfr_wdata = 8'h40;
        step();
        chk("viol_fill_ready", {7'd0, ready}, 8'h00);
        sfr_wdata = 8'h08;
        step();
        clear_strobes();
        chk("viol_psw", psw, 8'hFE);
        hold = 1'b0;
        step();
        chk("viol_commit_psw",   psw, 8'h40);
        chk("viol_commit_ready", {7'd0, ready}, 8'h01);
        step();
        chk("viol_after_psw", psw, 8'h40);

        // Reset while PEND drops the slot.
        hold = 1'b1;
        sfr_we = 1'b1; sfr_wdata = 8'h80;
        step();
        clear_strobes();
        chk("rstpend_ready", {7'd0, ready}, 8'h00);
        rst = 1'b1;
        step();
        chk("rstpend_psw",   psw, 8'h00);
        chk("rstpend_ready", {7'd0, ready}, 8'h01);
        rst  = 1'b0;
        hold = 1'b0;
        step();
        chk("rstpend_nolate1", psw, 8'h00);
        step();
        chk("rstpend_nolate2", psw, 8'h00);

        // Reset beats a same-cycle SFR write.
        rst = 1'b1;
        sfr_we = 1'b1; sfr_wdata = 8'hFF;
        step();
        clear_strobes();
        rst = 1'b0;
        chk("rst_prio_psw", psw, 8'h00);

        // P is read-only through both the bit and SFR paths.
        acc = 8'h03;
        bit_we = 1'b1; bit_sel = 3'd0; bit_val = 1'b1;
        step();
        clear_strobes();
        chk("bit0_ro", psw, 8'h00);
        acc = 8'h00;
        sfr_we = 1'b1; sfr_wdata = 8'h01;
        step();
        clear_strobes();
        chk("sfr0_ro", psw, 8'h00);

        // ZO only changes through the flag path.
        flag_we = 1'b1; flag_mask = 4'b0001; zo = 1'b1;
        step();
        clear_strobes();
        chk("zo_set",     {7'd0, zo_q}, 8'h01);
        chk("zo_set_psw", psw, 8'h00);
        sfr_we = 1'b1; sfr_wdata = 8'h00;
        step();
        clear_strobes();
        chk("zo_keep_sfr", {7'd0, zo_q}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
